// File: rtl/irr_sync.sv
// irr_sync: interrupt request register for an 8259A-compatible controller.
// Captures N_CH request lines and supports per-channel edge/level triggering,
// output-only masking and sticky edge overrun flags. Requests are cleared by
// acknowledge or by clear_all (controller re-initialisation).
// Optional macro IRR_SYNC_EN: inserts a 2-flop synchroniser on every ir_in
// line, which adds two cycles of capture latency.
module irr_sync #(
  parameter  int N_CH  = 8,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  ir_in,
  input  logic [N_CH-1:0]  ltim,
  input  logic [N_CH-1:0]  imr,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             clear_all,
  output logic [N_CH-1:0]  irr,
  output logic [N_CH-1:0]  irr_masked,
  output logic             interrupt_exists,
  output logic [N_CH-1:0]  overrun
);

  logic [N_CH-1:0] ir_s;       // conditioned request inputs
  logic [N_CH-1:0] ir_d_r;     // ir_s one cycle earlier, for edge detection
  logic [N_CH-1:0] ltim_q_r;   // trigger mode currently in force
  logic [N_CH-1:0] irr_r;
  logic [N_CH-1:0] ovr_r;
  logic [N_CH-1:0] irr_nxt_s;
  logic [N_CH-1:0] ovr_nxt_s;
  logic [N_CH-1:0] ack_hit_s;  // one-hot decode of the acknowledged channel
  logic [N_CH-1:0] rise_s;

`ifdef IRR_SYNC_EN
  logic [N_CH-1:0] sync1_r;
  logic [N_CH-1:0] sync2_r;

  // Two-flop synchroniser for pins that are asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= {N_CH{1'b0}};
      sync2_r <= {N_CH{1'b0}};
    end else begin
      sync1_r <= ir_in;
      sync2_r <= sync1_r;
    end
  end

  assign ir_s = sync2_r;
`else
  assign ir_s = ir_in;
`endif

  assign rise_s = ir_s & ~ir_d_r;

  // Decode the acknowledge; an out-of-range index matches no channel.
  always_comb begin
    ack_hit_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (ack_valid && (ack_idx == IDX_W'(i))) begin
        ack_hit_s[i] = 1'b1;
      end else begin
        ack_hit_s[i] = 1'b0;
      end
    end
  end

  // Per-channel next request/overrun state, highest-precedence event first.
  always_comb begin
    irr_nxt_s = irr_r;
    ovr_nxt_s = ovr_r;
    for (int i = 0; i < N_CH; i++) begin
      if (clear_all) begin
        irr_nxt_s[i] = 1'b0;
        ovr_nxt_s[i] = 1'b0;
      end else if (ltim[i] != ltim_q_r[i]) begin
        // Mode change: drop anything pending, new mode applies next cycle.
        irr_nxt_s[i] = 1'b0;
        ovr_nxt_s[i] = 1'b0;
      end else if (ltim_q_r[i]) begin
        // Level mode follows the input; an ack blanks it for one cycle.
        irr_nxt_s[i] = ir_s[i] & ~ack_hit_s[i];
        ovr_nxt_s[i] = 1'b0;
      end else if (rise_s[i]) begin
        // A fresh edge always registers; it overruns only an unacked request.
        irr_nxt_s[i] = 1'b1;
        ovr_nxt_s[i] = ack_hit_s[i] ? 1'b0 : (ovr_r[i] | irr_r[i]);
      end else if (ack_hit_s[i]) begin
        irr_nxt_s[i] = 1'b0;
        ovr_nxt_s[i] = 1'b0;
      end else begin
        irr_nxt_s[i] = irr_r[i];
        ovr_nxt_s[i] = ovr_r[i];
      end
    end
  end

  // Edge history and mode register; ir_d always reloads so that clear_all
  // and mode changes leave no stale edge behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_d_r   <= {N_CH{1'b0}};
      ltim_q_r <= {N_CH{1'b0}};
    end else begin
      ir_d_r   <= ir_s;
      ltim_q_r <= ltim;
    end
  end

  // Request and overrun state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irr_r <= {N_CH{1'b0}};
      ovr_r <= {N_CH{1'b0}};
    end else begin
      irr_r <= irr_nxt_s;
      ovr_r <= ovr_nxt_s;
    end
  end

  assign irr              = irr_r;
  assign overrun          = ovr_r;
  assign irr_masked       = irr_r & ~imr;
  assign interrupt_exists = |irr_masked;

endmodule

// File: tb/tb_irr_sync.sv
// Testbench for irr_sync: table-driven directed vectors on an 8-channel
// instance, hand-written async-reset / out-of-range-ack sequences, and a
// randomized run on a 6-channel instance against a rule-based model.
module tb_irr_sync;

`ifdef IRR_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  logic reset;

  // 8-channel instance
  logic [7:0] ir_in, ltim, imr, irr, irr_masked, overrun;
  logic       ack_valid, clear_all, interrupt_exists;
  logic [2:0] ack_idx;

  // 6-channel instance
  logic [5:0] ir6, ltim6, imr6, irr6, msk6, ovr6;
  logic       av6, ca6, ie6;
  logic [2:0] ai6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irr_sync #(.N_CH(8)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .ltim(ltim), .imr(imr),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .clear_all(clear_all),
    .irr(irr), .irr_masked(irr_masked), .interrupt_exists(interrupt_exists),
    .overrun(overrun)
  );

  irr_sync #(.N_CH(6)) dut6 (
    .clk(clk), .reset(reset), .ir_in(ir6), .ltim(ltim6), .imr(imr6),
    .ack_valid(av6), .ack_idx(ai6), .clear_all(ca6),
    .irr(irr6), .irr_masked(msk6), .interrupt_exists(ie6),
    .overrun(ovr6)
  );

  typedef struct {
    logic [7:0] ir;
    logic [7:0] lt;
    logic [7:0] im;
    logic       av;
    logic [2:0] ai;
    logic       ca;
    logic [7:0] e_irr;
    logic [7:0] e_ovr;
  } vec_t;

  vec_t tbl[28];

  // Reference model state for the 6-channel instance
  logic [5:0] m_irr, m_ovr, m_prev_s, m_prev_lt;
  logic [5:0] pipe0, pipe1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply the specification's rules for one clock edge given the inputs
  // currently presented and the conditioned input value s seen at that edge.
  task automatic model_edge(input logic [5:0] s);
    logic [5:0] ni;
    logic [5:0] no;
    ni = m_irr;
    no = m_ovr;
    for (int c = 0; c < 6; c++) begin
      bit acked;
      bit rose;
      acked = av6 && (int'(ai6) == c);
      rose  = s[c] && !m_prev_s[c];
      if (ca6 || (ltim6[c] != m_prev_lt[c])) begin
        ni[c] = 1'b0;
        no[c] = 1'b0;
      end else if (m_prev_lt[c]) begin
        ni[c] = s[c] && !acked;
        no[c] = 1'b0;
      end else if (rose) begin
        no[c] = acked ? 1'b0 : (m_ovr[c] || m_irr[c]);
        ni[c] = 1'b1;
      end else if (acked) begin
        ni[c] = 1'b0;
        no[c] = 1'b0;
      end
    end
    m_irr     = ni;
    m_ovr     = no;
    m_prev_s  = s;
    m_prev_lt = ltim6;
  endtask

  initial begin
    logic [7:0] em;
    logic [5:0] s_now;

    //           ir     ltim   imr    av    ai    ca    irr    ovr
    tbl[0]  = '{8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{8'h04, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h04, 8'h00};
    tbl[2]  = '{8'h04, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h04, 8'h00};
    tbl[3]  = '{8'h04, 8'h00, 8'h00, 1'b1, 3'd2, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{8'h04, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{8'h20, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h20, 8'h00};
    tbl[6]  = '{8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h20, 8'h00};
    tbl[7]  = '{8'h20, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h20, 8'h20};
    tbl[8]  = '{8'h00, 8'h00, 8'h00, 1'b1, 3'd5, 1'b0, 8'h00, 8'h00};
    tbl[9]  = '{8'h08, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h08, 8'h00};
    tbl[10] = '{8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h08, 8'h00};
    tbl[11] = '{8'h08, 8'h00, 8'h00, 1'b1, 3'd3, 1'b0, 8'h08, 8'h00};
    tbl[12] = '{8'h00, 8'h00, 8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 8'h00};
    tbl[13] = '{8'h03, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h03, 8'h00};
    tbl[14] = '{8'h13, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 8'h00};
    tbl[15] = '{8'h13, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00};
    tbl[16] = '{8'h0C, 8'h00, 8'h04, 1'b0, 3'd0, 1'b0, 8'h0C, 8'h00};
    tbl[17] = '{8'h0C, 8'h00, 8'h0C, 1'b0, 3'd0, 1'b0, 8'h0C, 8'h00};
    tbl[18] = '{8'h81, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00};
    tbl[19] = '{8'h81, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h81, 8'h00};
    tbl[20] = '{8'h81, 8'hFF, 8'h00, 1'b1, 3'd7, 1'b0, 8'h01, 8'h00};
    tbl[21] = '{8'h81, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h81, 8'h00};
    tbl[22] = '{8'h00, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00};
    tbl[23] = '{8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00};
    tbl[24] = '{8'h02, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h02, 8'h00};
    tbl[25] = '{8'h02, 8'h02, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00};
    tbl[26] = '{8'h02, 8'h02, 8'h00, 1'b0, 3'd0, 1'b0, 8'h02, 8'h00};
    tbl[27] = '{8'h00, 8'h02, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00};

    reset = 1'b1;
    ir_in = 8'h00; ltim = 8'h00; imr = 8'h00;
    ack_valid = 1'b0; ack_idx = 3'd0; clear_all = 1'b0;
    ir6 = 6'h00; ltim6 = 6'h00; imr6 = 6'h00;
    av6 = 1'b0; ai6 = 3'd0; ca6 = 1'b0;
    repeat (2) step();

    chk("reset irr", 32'(irr), 32'h0);
    chk("reset overrun", 32'(overrun), 32'h0);
    chk("reset irr_masked", 32'(irr_masked), 32'h0);
    chk("reset interrupt_exists", 32'(interrupt_exists), 32'h0);
    reset = 1'b0;

    // Directed table on the 8-channel instance
    for (int i = 0; i < 28; i++) begin
      ir_in = tbl[i].ir; ltim = tbl[i].lt; imr = tbl[i].im;
      ack_valid = tbl[i].av; ack_idx = tbl[i].ai; clear_all = tbl[i].ca;
      step();
      em = tbl[i].e_irr & ~tbl[i].im;
      chk($sformatf("row%0d irr", i), 32'(irr), 32'(tbl[i].e_irr));
      chk($sformatf("row%0d overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
      chk($sformatf("row%0d irr_masked", i), 32'(irr_masked), 32'(em));
      chk($sformatf("row%0d interrupt_exists", i), 32'(interrupt_exists), 32'(|em));
    end
    ack_valid = 1'b0; clear_all = 1'b0;

    // Masking acts in the same cycle, without a clock edge
    ir_in = 8'h01;
    step();
    chk("pre-mask irr", 32'(irr), 32'h01);
    imr = 8'h01;
    #1;
    chk("same-cycle mask ie", 32'(interrupt_exists), 32'h0);
    chk("same-cycle mask irr", 32'(irr), 32'h01);
    imr = 8'h00;
    #1;
    chk("same-cycle unmask ie", 32'(interrupt_exists), 32'h1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("async reset irr", 32'(irr), 32'h0);
    chk("async reset ie", 32'(interrupt_exists), 32'h0);
    step();
    reset = 1'b0;
    // Input held high across reset release is seen as a rise (ch0 edge mode)
    step();
    chk("rise at release", 32'(irr), 32'h01);

    // Out-of-range acknowledge on the 6-channel instance
    ir6 = 6'h01;
    step();
    chk("n6 capture", 32'(irr6), 32'h01);
    av6 = 1'b1; ai6 = 3'd7;
    step();
    chk("n6 ack idx7 ignored", 32'(irr6), 32'h01);
    av6 = 1'b0; ai6 = 3'd0; ir6 = 6'h00;

    // Randomized run on the 6-channel instance against the model
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_irr = 6'h0; m_ovr = 6'h0; m_prev_s = 6'h0; m_prev_lt = 6'h0;
    pipe0 = 6'h0; pipe1 = 6'h0;
    for (int k = 0; k < 400; k++) begin
      ir6  = 6'($urandom);
      imr6 = 6'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        ltim6[$urandom_range(0, 5)] ^= 1'b1;
      end
      av6 = ($urandom_range(0, 2) == 0);
      ai6 = 3'($urandom_range(0, 7));
      ca6 = ($urandom_range(0, 24) == 0);
      if (L == 1) begin
        s_now = ir6;
      end else begin
        s_now = pipe1;
      end
      model_edge(s_now);
      pipe1 = pipe0;
      pipe0 = ir6;
      step();
      chk($sformatf("rnd%0d irr", k), 32'(irr6), 32'(m_irr));
      chk($sformatf("rnd%0d overrun", k), 32'(ovr6), 32'(m_ovr));
      chk($sformatf("rnd%0d irr_masked", k), 32'(msk6), 32'(m_irr & ~imr6));
      chk($sformatf("rnd%0d ie", k), 32'(ie6), 32'(|(m_irr & ~imr6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irr_sync.md
# irr_sync

Synchronous, parametrised interrupt request register for the 8259A-compatible controller. It captures `N_CH` interrupt inputs on one clock and supports per-channel edge/level trigger mode, masking, and per-channel overrun flags. Requests are cleared on acknowledge or controller re-initialisation. It sits between the IR pins and the priority resolver, which consumes `irr_masked` and returns the acknowledged index.

## Interface
- `N_CH`, 8: number of interrupt channels, 2..32; `IDX_W = $clog2(N_CH)` is derived and is not overridable.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ir_in`  in  N_CH  raw interrupt request inputs, asynchronous to `clk`.
- `ltim`  in  N_CH  per-channel trigger mode: 1 = level, 0 = edge.
- `imr`  in  N_CH  mask; 1 = masked (affects outputs only, never capture).
- `ack_valid`  in  1  one-cycle strobe: acknowledge channel `ack_idx`.
- `ack_idx`  in  IDX_W  channel being acknowledged.
- `clear_all`  in  1  one-cycle strobe (ICW1 write): clear every request and overrun.
- `irr`  out  N_CH  registered request register.
- `irr_masked`  out  N_CH  `irr & ~imr`, combinational.
- `interrupt_exists`  out  1  `|irr_masked`, combinational.
- `overrun`  out  N_CH  registered sticky flag: edge request arrived while the bit was already pending.

## Operation
- Input path: `ir_s` is the conditioned input (see Configuration). `ir_d` is `ir_s` registered; `ltim_q` is `ltim` registered.
- Edge channel (`ltim_q[i]=0`):
  - rise = `ir_s[i] & ~ir_d[i]`.
  - rise sets `irr[i]`. Once set, the bit holds until ack or `clear_all`, even if the input drops.
  - rise while `irr[i]=1` and no ack of `i` this cycle sets `overrun[i]`.
- Level channel (`ltim_q[i]=1`):
  - `irr[i] <= ir_s[i]` every cycle.
  - An ack of `i` forces `irr[i]` to 0 for that cycle. If the input is still high, the bit re-asserts the next cycle.
  - `overrun[i]` is never set in level mode.
- Acknowledge: `ack_valid` with `ack_idx < N_CH` clears `irr[ack_idx]` and `overrun[ack_idx]`. If `ack_idx >= N_CH`, the ack is ignored with no state change.
- Mode change: when `ltim[i] != ltim_q[i]`, in that cycle:
  - `irr[i]` and `overrun[i]` are cleared.
  - `ir_d[i]` loads `ir_s[i]`, so no spurious edge results.
  - the new mode takes effect the following cycle.
- Precedence within a cycle for channel `i`:
  - `reset` over `clear_all`, over mode change, over the rest.
  - Edge mode: a rise coinciding with an ack of `i` sets `irr[i]=1` (new event) and clears `overrun[i]`.
  - Level mode: ack wins for that cycle.
- `clear_all`:
  - `irr` and `overrun` go to 0.
  - `ir_d` loads `ir_s`, so inputs already high do not produce an edge.
  - Level channels recapture from the next cycle.
- `imr` is never stored; masking or unmasking changes `irr_masked` and `interrupt_exists` in the same cycle.

## Timing
- Reset values: `irr=0`, `overrun=0`, `irr_masked=0`, `interrupt_exists=0`, synchroniser flops=0, `ir_d=0`, `ltim_q=0`.
- An input already high at reset release is seen as a rise in edge mode.
- Capture latency L from the `clk` edge that first samples a new `ir_in` value to `irr` change: L=3 with the synchroniser, L=1 without.
- Ack latency: `irr[ack_idx]` is 0 after the `clk` edge that samples `ack_valid`. `irr_masked` and `interrupt_exists` follow combinationally.
- Minimum edge-mode pulse: high for at least 1 cycle and low for at least 1 cycle between requests. Shorter pulses may be lost.
- `reset` asserting mid-operation clears all state asynchronously. Release is synchronised upstream.

## Configuration
- `IRR_SYNC_EN` defined:
  - `ir_in` passes through a 2-flop synchroniser per channel; `ir_s` is the second flop.
  - L=3; safe for truly asynchronous pins.
- `IRR_SYNC_EN` undefined:
  - `ir_s = ir_in` directly; L=1.
  - Inputs must be synchronous to `clk`.
- No other behaviour differs.

## Test plan
- Edge capture: N_CH=8, `ltim=0`, ch2 0→1 → `irr=8'h04` after L edges. Keeping ch2 high → no further change. Ack idx 2 → `irr=0`. Holding ch2 high after the ack → `irr` stays 0.
- Overrun: ch5 edge, drop, edge again with no ack → `irr[5]=1`, `overrun=8'h20`. Ack idx 5 → both 0.
- Level follow: `ltim=8'hFF`, `ir_in=8'h81` → `irr=8'h81`. Ack idx 7 → `irr=8'h01` for 1 cycle, then 8'h81. `ir_in=0` → `irr=0` after L edges.
- Masking: `irr=8'h0C`, `imr=8'h04` → `irr_masked=8'h08`, `interrupt_exists=1`. `imr=8'h0C` → `interrupt_exists=0` in the same cycle, with `irr` unchanged.
- Simultaneous/boundary:
  - edge ch3 rise in the same cycle as ack idx 3 → `irr[3]=1`, `overrun[3]=0`.
  - `ack_idx=7` with N_CH=6 → no change.
  - `clear_all` with inputs high in edge mode → `irr=0`, no recapture.
- Mode switch/reset:
  - ch1 pending in edge mode, toggle `ltim[1]` → `irr[1]=0` next edge, no spurious set. Level mode then captures the input from the following cycle.
  - Assert `reset` asynchronously between edges → all outputs 0 immediately.
